// File: rtl/alu_pkg.sv
// Shared definitions for the registered 32-bit ALU: op codes and default width.
package alu_pkg;

    localparam int DWIDTH_DEF = 32;

    // Op code is {mode, opsel}; mode=1 selects the logic group.
    typedef enum logic [3:0] {
        OP_ADD    = 4'h0,
        OP_SUBWB  = 4'h1,
        OP_MOV    = 4'h2,
        OP_SUB    = 4'h3,
        OP_INC    = 4'h4,
        OP_DEC    = 4'h5,
        OP_ADDINC = 4'h6,
        OP_LAND   = 4'h8,
        OP_LOR    = 4'h9,
        OP_LXOR   = 4'hA,
        OP_LNOT   = 4'hB,
        OP_MOVE   = 4'hC,
        OP_LSHL   = 4'hD
    } op_e;

endpackage

// File: rtl/alu_addsub.sv
// Shared adder for all arithmetic ops; subtract is a + ~b + cin with borrow = ~cout.
module alu_addsub
    import alu_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF
) (
    input  logic [DWIDTH-1:0] a,
    input  logic [DWIDTH-1:0] b,
    input  logic              inv_b,
    input  logic              cin,
    output logic [DWIDTH-1:0] sum,
    output logic              cout,
    output logic              ovf
);

    logic [DWIDTH-1:0] b_eff;

    always_comb begin
        b_eff       = inv_b ? ~b : b;
        {cout, sum} = {1'b0, a} + {1'b0, b_eff} + {{DWIDTH{1'b0}}, cin};
        // Overflow judged on the operands the adder actually sees.
        ovf         = (a[DWIDTH-1] == b_eff[DWIDTH-1]) && (sum[DWIDTH-1] != a[DWIDTH-1]);
    end

endmodule

// File: rtl/alu_32_bit.sv
// Registered ALU: op decode, logic/shift mux and output flag registers (1-cycle latency).
module alu_32_bit
    import alu_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DWIDTH-1:0] op1,
    input  logic [DWIDTH-1:0] op2,
    input  logic [2:0]        opsel,
    input  logic              mode,
    output logic [DWIDTH-1:0] result,
    output logic              c_flag,
    output logic              z_flag,
    output logic              o_flag,
    output logic              s_flag
);

    localparam int SHW = $clog2(DWIDTH);

    op_e               op;
    logic [DWIDTH-1:0] as_b, as_sum;
    logic              as_inv, as_cin, as_cout, as_ovf;
    logic [DWIDTH:0]   shl_ext;

    logic [DWIDTH-1:0] result_d, result_q;
    logic              c_flag_d, c_flag_q;
    logic              z_flag_d, z_flag_q;
    logic              o_flag_d, o_flag_q;
    logic              s_flag_d, s_flag_q;

    assign op = op_e'({mode, opsel});

    always_comb begin
        as_b   = op2;
        as_inv = 1'b0;
        as_cin = 1'b0;
        unique case (op)
            OP_SUBWB:  begin as_inv = 1'b1; as_cin = ~c_flag_q; end
            OP_SUB:    begin as_inv = 1'b1; as_cin = 1'b1; end
            OP_INC:    as_b = DWIDTH'(1);
            OP_DEC:    begin as_b = DWIDTH'(1); as_inv = 1'b1; as_cin = 1'b1; end
            OP_ADDINC: as_cin = 1'b1;
            default:   ;
        endcase
    end

    alu_addsub #(.DWIDTH(DWIDTH)) u_addsub (
        .a     (op1),
        .b     (as_b),
        .inv_b (as_inv),
        .cin   (as_cin),
        .sum   (as_sum),
        .cout  (as_cout),
        .ovf   (as_ovf)
    );

    // Extra top bit catches the last bit shifted out; stays 0 for a zero shift.
    assign shl_ext = {1'b0, op1} << op2[SHW-1:0];

    always_comb begin
        result_d = '0;
        c_flag_d = 1'b0;
        o_flag_d = 1'b0;
        case (op)
            OP_ADD, OP_INC, OP_ADDINC: begin
                result_d = as_sum;
                c_flag_d = as_cout;
                o_flag_d = as_ovf;
            end
            OP_SUBWB, OP_SUB, OP_DEC: begin
                result_d = as_sum;
                c_flag_d = ~as_cout;
                o_flag_d = as_ovf;
            end
            OP_MOV:  result_d = op1;
            OP_LAND: result_d = op1 & op2;
            OP_LOR:  result_d = op1 | op2;
            OP_LXOR: result_d = op1 ^ op2;
            OP_LNOT: result_d = ~op1;
            OP_MOVE: result_d = op2;
            OP_LSHL: begin
                result_d = shl_ext[DWIDTH-1:0];
                c_flag_d = shl_ext[DWIDTH];
            end
            default: ;
        endcase
        z_flag_d = (result_d == '0);
        s_flag_d = result_d[DWIDTH-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_q <= '0;
            c_flag_q <= 1'b0;
            z_flag_q <= 1'b0;
            o_flag_q <= 1'b0;
            s_flag_q <= 1'b0;
        end else begin
            result_q <= result_d;
            c_flag_q <= c_flag_d;
            z_flag_q <= z_flag_d;
            o_flag_q <= o_flag_d;
            s_flag_q <= s_flag_d;
        end
    end

    assign result = result_q;
    assign c_flag = c_flag_q;
    assign z_flag = z_flag_q;
    assign o_flag = o_flag_q;
    assign s_flag = s_flag_q;

endmodule

// File: tb/tb_alu_32_bit.sv
// Directed-vector bench for alu_32_bit with hand-computed expectations.
module tb_alu_32_bit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] op1 = '0, op2 = '0;
    logic [2:0]  opsel = '0;
    logic        mode = 1'b0;
    logic [31:0] result;
    logic        c_flag, z_flag, o_flag, s_flag;

    int n_cmp = 0;
    int n_bad = 0;

    alu_32_bit #(.DWIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .op1    (op1),
        .op2    (op2),
        .opsel  (opsel),
        .mode   (mode),
        .result (result),
        .c_flag (c_flag),
        .z_flag (z_flag),
        .o_flag (o_flag),
        .s_flag (s_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] r,
                           input logic c, input logic z, input logic o, input logic s);
        chk({tag, ".res"}, result, r);
        chk({tag, ".c"}, 32'(c_flag), 32'(c));
        chk({tag, ".z"}, 32'(z_flag), 32'(z));
        chk({tag, ".o"}, 32'(o_flag), 32'(o));
        chk({tag, ".s"}, 32'(s_flag), 32'(s));
    endtask

    task automatic set_in(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b);
        mode  = code[3];
        opsel = code[2:0];
        op1   = a;
        op2   = b;
    endtask

    task automatic do_op(input logic [3:0] code, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        set_in(code, a, b);
        @(posedge clk);
        #1;
    endtask

    // Pulse reset between edges, then load the op that the first edge after release computes.
    task automatic mid_reset(input string tag, input logic [3:0] code,
                             input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        #1 rst = 1'b1;
        #1 chk_all({tag, ".rst"}, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        set_in(code, a, b);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        chk_all("por", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        do_op(4'h0, 32'h1234_5678, 32'h8000_0000);
        chk_all("add_pre", 32'h9234_5678, 1'b0, 1'b0, 1'b0, 1'b1);

        mid_reset("r1", 4'h3, 32'h0, 32'h1);
        chk_all("sub0m1", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1);

        do_op(4'h1, 32'd10, 32'd3);
        chk_all("subwb_chain", 32'd6, 1'b0, 1'b0, 1'b0, 1'b0);
        do_op(4'h3, 32'd5, 32'd5);
        chk_all("sub_eq", 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);

        do_op(4'h6, 32'hEEEE_EEEE, 32'hEEEE_EEEE);
        chk_all("addinc_big", 32'hDDDD_DDDD, 1'b1, 1'b0, 1'b0, 1'b1);
        do_op(4'h6, 32'h0000_00EE, 32'h0000_00EE);
        chk_all("addinc_small", 32'h0000_01DD, 1'b0, 1'b0, 1'b0, 1'b0);

        do_op(4'h0, 32'h7FFF_FFFF, 32'h1);
        chk_all("add_ovf", 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b1);
        do_op(4'h3, 32'h8000_0000, 32'h1);
        chk_all("sub_ovf", 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0);

        do_op(4'h4, 32'hFFFF_FFFF, 32'h5555_5555);
        chk_all("inc_wrap", 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        do_op(4'h5, 32'h0, 32'h5555_5555);
        chk_all("dec_wrap", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1);
        do_op(4'h2, 32'hCAFE_0001, 32'h0);
        chk_all("mov", 32'hCAFE_0001, 1'b0, 1'b0, 1'b0, 1'b1);

        do_op(4'h8, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        chk_all("and", 32'h00F0_00F0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_op(4'h9, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        chk_all("or", 32'hFFF0_FFF0, 1'b0, 1'b0, 1'b0, 1'b1);
        do_op(4'hA, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        chk_all("xor", 32'hFF00_FF00, 1'b0, 1'b0, 1'b0, 1'b1);
        do_op(4'hB, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        chk_all("not", 32'h0F0F_0F0F, 1'b0, 1'b0, 1'b0, 1'b0);
        do_op(4'hC, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
        chk_all("move", 32'h0FF0_0FF0, 1'b0, 1'b0, 1'b0, 1'b0);

        do_op(4'hD, 32'h8000_0001, 32'h1);
        chk_all("shl1", 32'h0000_0002, 1'b1, 1'b0, 1'b0, 1'b0);
        do_op(4'hD, 32'h8000_0001, 32'h0);
        chk_all("shl0", 32'h8000_0001, 1'b0, 1'b0, 1'b0, 1'b1);
        do_op(4'hD, 32'h0000_0003, 32'h0000_003F);
        chk_all("shl31", 32'h8000_0000, 1'b1, 1'b0, 1'b0, 1'b1);

        do_op(4'h7, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        chk_all("rsv7", 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        do_op(4'hF, 32'h1234_5678, 32'h1);
        chk_all("rsvF", 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Leave C set, then reset: the first subwb after release must see C_prev = 0.
        do_op(4'h3, 32'h0, 32'h1);
        chk_all("sub_cset", 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1);
        mid_reset("r2", 4'h1, 32'd10, 32'd3);
        chk_all("subwb_post_rst", 32'd7, 1'b0, 1'b0, 1'b0, 1'b0);

        // Inputs changing between edges stay invisible until the next edge.
        @(negedge clk);
        set_in(4'h0, 32'd1, 32'd1);
        #2 chk("hold", result, 32'd7);
        @(posedge clk);
        #1 chk("hold_next", result, 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_32_bit.md
# alu_32_bit

Registered 32-bit integer ALU for the datapath execute stage: combines two operands under a 4-bit operation code and produces a result plus carry, zero, overflow and sign flags. All outputs are registered, with one cycle of latency. The carry flag is held in state and feeds the subtract-with-borrow operation for multi-word arithmetic.

## Interface
- `DWIDTH`, default 32: operand/result width. All behaviour below is written for 32; bit `DWIDTH-1` is the sign bit.
- `clk` input, 1: single clock, rising edge.
- `rst` input, 1: reset, asynchronous and active-high.
- `op1` input, DWIDTH: first operand (A).
- `op2` input, DWIDTH: second operand (B).
- `opsel` input, 3: operation select within the group chosen by `mode`.
- `mode` input, 1: 0 = arithmetic group, 1 = logic group.
- `result` output, DWIDTH: registered result.
- `c_flag` output, 1: registered carry out, or borrow for subtracts.
- `z_flag` output, 1: registered, set when `result` is 0.
- `o_flag` output, 1: registered signed overflow.
- `s_flag` output, 1: registered sign, equal to `result[DWIDTH-1]`.

## Operation
Op code is {mode, opsel}. C_prev is the current registered `c_flag`.
- 0x0 add: A+B; C = carry out; O = signed overflow.
- 0x1 subwb: A−B−C_prev; C = borrow; O = signed overflow.
- 0x2 mov: result = A; C = 0; O = 0.
- 0x3 sub: A−B; C = borrow, i.e. set when A < B unsigned; O = signed overflow.
- 0x4 inc: A+1; C and O as for add with B = 1.
- 0x5 dec: A−1; C and O as for sub with B = 1.
- 0x6 addinc: A+B+1; C = carry out; O = signed overflow.
- 0x8 and: A & B.
- 0x9 or: A | B.
- 0xA xor: A ^ B.
- 0xB not: ~A, B ignored.
- 0xC move: result = B.
- 0xD shl: A << B[4:0]. C = last bit shifted out, 0 when the shift amount is 0. O = 0.
- Logic ops other than shl: C = 0, O = 0.
- Reserved codes 0x7, 0xE, 0xF: result = 0, C = 0, O = 0.
- Every op: Z = (result == 0) and S = result[31].
- Signed overflow is set when the operands, as seen by the adder, share a sign that differs from the sign of the result.
- Arithmetic is modulo 2^32; a 33-bit internal sum supplies C.

## Timing
- Next-state values are combinational from `op1`, `op2`, `opsel`, `mode` and C_prev.
- Next-state values are captured on every rising `clk` edge.
- Latency is 1 cycle and throughput is 1 op per cycle. There is no handshake and no enable.
- `rst` asserted clears all outputs immediately, without waiting for a clock edge: `result` = 0, `c_flag` = 0, `o_flag` = 0, `s_flag` = 0, `z_flag` = 0.
- `rst` asserted in the middle of an op sequence discards any pending value.
- The first edge after `rst` deasserts computes subwb with C_prev = 0.
- subwb in consecutive cycles chains borrows, because C_prev is the flag written on the previous edge.
- Changing inputs between edges has no visible effect until the next edge.

## Structure
- Shared package `alu_pkg`:
  - 4-bit op enum: add, subwb, mov, sub, inc, dec, addinc, land, lor, lxor, lnot, move, lshl, with the codes listed above.
  - `DWIDTH` default.
- One sub-module, `alu_addsub`, is natural.
  - Inputs: A, B, invert-B, carry-in.
  - Outputs: sum, carry out, overflow.
  - Shared by all arithmetic ops. A subtract is built as A + ~B + 1 with the borrow taken as the inverted carry out.
- The top level contains the op decode, the logic/shift mux and the output registers.

## Test plan
- Reset behaviour:
  - Assert `rst` mid-stream with no clock edge. All outputs must be 0 immediately.
  - After release, sub with A = 0, B = 1 → `result` 0xFFFFFFFF, C = 1, S = 1.
- addinc, two cases:
  - A = B = 0xEEEEEEEE → 0xDDDDDDDD, C = 1, O = 0, S = 1, Z = 0.
  - A = B = 0x000000EE → 0x000001DD, all flags 0.
- add with A = 0x7FFFFFFF, B = 1 → 0x80000000, O = 1, S = 1, C = 0.
- Borrow chain:
  - sub with A = 0, B = 1 gives C = 1.
  - Next cycle, subwb with A = 10, B = 3 → 6, C = 0.
  - Then sub with A = 5, B = 5 → 0, Z = 1.
- Logic group, with A = 0xF0F0F0F0, B = 0x0FF00FF0:
  - and → 0x00F000F0
  - or → 0xFFF0FFF0
  - xor → 0xFF00FF00
  - not → 0x0F0F0F0F
  - move → 0x0FF00FF0
- Shift and reserved codes:
  - shl with A = 0x80000001, B = 1 → 0x00000002, C = 1.
  - Codes 0x7 and 0xF → `result` 0 with Z = 1.
